// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared definitions for the JK sequencer controller.
//   - OP_HOLD / OP_UP / OP_DOWN / OP_LOAD : 2-bit command opcodes
//   - state_t                            : controller FSM state encoding
package jk_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/jk_ff.sv
// jk_ff: single JK flip-flop stage with asynchronous active-low reset.
// Ports:
//   J, K   : excitation inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, forces Q = 0
//   Q      : stage output
module jk_ff (
  input  logic J,
  input  logic K,
  input  logic clk,
  input  logic rst_n,
  output logic Q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command-driven controller that steps a register built from
// WIDTH JK flip-flops. A command (HOLD/UP/DOWN/LOAD plus a step count) is
// accepted in IDLE, executed one step per clock in RUN, and completion is
// signalled by a one-cycle done pulse in DONE.
//
// Parameters:
//   WIDTH : number of JK stages
//   STEPW : width of the step-count field
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op, cmd_steps   : opcode and step count
//   din                 : LOAD target value
//   j, k                : excitation driven to each JK stage
//   q                   : register state (JK stage outputs)
//   busy, done          : executing flag, completion pulse
// Configuration:
//   JK_SEQ_SAT_EN : when defined, UP saturates at all-ones and DOWN at zero
//                   instead of wrapping.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEPW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [STEPW-1:0] step_cnt, step_cnt_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] din_r;
  logic [WIDTH-1:0] next_val;
  logic             accept;

  assign accept = cmd_valid && (state == IDLE);

  // Control state: FSM and remaining-step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
    end
  end

  // Command payload: only meaningful while a command runs, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= cmd_op;
      din_r <= din;
    end
  end

  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // LOAD is a single step regardless of the requested count
          if (cmd_op == OP_LOAD) begin
            step_cnt_nxt = STEPW'(1);
            state_nxt    = RUN;
          end else begin
            step_cnt_nxt = cmd_steps;
            state_nxt    = (cmd_steps == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        busy         = 1'b1;
        step_cnt_nxt = step_cnt - STEPW'(1);
        if (step_cnt == STEPW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Target value for the next RUN edge
  always_comb begin
    next_val = q;
    case (op_r)
      OP_UP: begin
`ifdef JK_SEQ_SAT_EN
        next_val = (q == '1) ? q : q + WIDTH'(1);
`else
        next_val = q + WIDTH'(1);
`endif
      end
      OP_DOWN: begin
`ifdef JK_SEQ_SAT_EN
        next_val = (q == '0) ? q : q - WIDTH'(1);
`else
        next_val = q - WIDTH'(1);
`endif
      end
      OP_LOAD: next_val = din_r;
      default: next_val = q;
    endcase
  end

  // Minimal excitation: set only 0->1 bits, reset only 1->0 bits
  always_comb begin
    j = '0;
    k = '0;
    if (state == RUN) begin
      j = ~q & next_val;
      k = q & ~next_val;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_ff u_ff (
      .J     (j[i]),
      .K     (k[i]),
      .clk   (clk),
      .rst_n (rst_n),
      .Q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
module tb_jk_seq_ctrl;
  import jk_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int STEPW = 4;

`ifdef JK_SEQ_SAT_EN
  localparam logic [3:0] UP_END   = 4'hF;
  localparam logic [3:0] DOWN_END = 4'h0;
  localparam logic [3:0] J_AT_F   = 4'h0;
  localparam logic [3:0] K_AT_F   = 4'h0;
  localparam logic [3:0] J_AT_0   = 4'h0;
`else
  localparam logic [3:0] UP_END   = 4'h0;
  localparam logic [3:0] DOWN_END = 4'hF;
  localparam logic [3:0] J_AT_F   = 4'h0;
  localparam logic [3:0] K_AT_F   = 4'hF;
  localparam logic [3:0] J_AT_0   = 4'hF;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_steps = 4'h0;
  logic [3:0] din = 4'h0;
  logic [3:0] j, k, q;
  logic       busy, done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jk_seq_ctrl #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_steps (cmd_steps),
    .din       (din),
    .j         (j),
    .k         (k),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] st, input logic [3:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = st;
    din       = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load_val(input logic [3:0] v);
    issue(OP_LOAD, 4'h0, v);
    tick();
    tick();
  endtask

  task automatic test_reset();
    #2;
    total++; if (q !== 4'h0) begin bad++; $display("FAIL rst_q got=%h want=0", q); end
    total++; if ({busy, done, cmd_ready} !== 3'b001) begin bad++; $display("FAIL rst_flags got=%b want=001", {busy, done, cmd_ready}); end
    total++; if ({j, k} !== 8'h00) begin bad++; $display("FAIL rst_jk got=%h want=00", {j, k}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    issue(OP_LOAD, 4'h7, 4'hA);
    total++; if ({busy, cmd_ready, done} !== 3'b100) begin bad++; $display("FAIL load_run_flags got=%b want=100", {busy, cmd_ready, done}); end
    total++; if (j !== 4'hA) begin bad++; $display("FAIL load_j got=%b want=1010", j); end
    total++; if (k !== 4'h0) begin bad++; $display("FAIL load_k got=%b want=0000", k); end
    tick();
    total++; if (q !== 4'hA) begin bad++; $display("FAIL load_q got=%h want=a", q); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL load_done got=%b want=1", done); end
    total++; if ({j, k} !== 8'h00) begin bad++; $display("FAIL load_jk_done got=%h want=00", {j, k}); end
    tick();
    total++; if ({done, busy, cmd_ready} !== 3'b001) begin bad++; $display("FAIL load_idle got=%b want=001", {done, busy, cmd_ready}); end
  endtask

  task automatic test_up_wrap();
    load_val(4'hD);
    issue(OP_UP, 4'h3, 4'h0);
    total++; if ({j, k} !== 8'h21) begin bad++; $display("FAIL up_jk_d got=%h want=21", {j, k}); end
    tick();
    total++; if (q !== 4'hE) begin bad++; $display("FAIL up_q1 got=%h want=e", q); end
    tick();
    total++; if (q !== 4'hF) begin bad++; $display("FAIL up_q2 got=%h want=f", q); end
    total++; if ({j, k} !== {J_AT_F, K_AT_F}) begin bad++; $display("FAIL up_jk_f got=%h want=%h", {j, k}, {J_AT_F, K_AT_F}); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL up_early_done got=%b want=0", done); end
    tick();
    total++; if (q !== UP_END) begin bad++; $display("FAIL up_q3 got=%h want=%h", q, UP_END); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL up_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_down_wrap();
    load_val(4'h1);
    issue(OP_DOWN, 4'h2, 4'h0);
    total++; if ({j, k} !== 8'h01) begin bad++; $display("FAIL down_jk_1 got=%h want=01", {j, k}); end
    tick();
    total++; if (q !== 4'h0) begin bad++; $display("FAIL down_q1 got=%h want=0", q); end
    total++; if ({j, k} !== {J_AT_0, 4'h0}) begin bad++; $display("FAIL down_jk_0 got=%h want=%h", {j, k}, {J_AT_0, 4'h0}); end
    tick();
    total++; if (q !== DOWN_END) begin bad++; $display("FAIL down_q2 got=%h want=%h", q, DOWN_END); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL down_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_hold();
    int n;
    load_val(4'h5);
    issue(OP_HOLD, 4'h5, 4'h0);
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      total++; if ({j, k} !== 8'h00) begin bad++; $display("FAIL hold_jk got=%h want=00", {j, k}); end
      total++; if (q !== 4'h5) begin bad++; $display("FAIL hold_q got=%h want=5", q); end
      n++;
      tick();
    end
    total++; if (n !== 6) begin bad++; $display("FAIL hold_busy_cycles got=%0d want=6", n); end
  endtask

  task automatic test_zero_steps();
    issue(OP_UP, 4'h0, 4'h0);
    total++; if ({done, busy} !== 2'b11) begin bad++; $display("FAIL zero_done got=%b want=11", {done, busy}); end
    total++; if (q !== 4'h5) begin bad++; $display("FAIL zero_q got=%h want=5", q); end
    total++; if ({j, k} !== 8'h00) begin bad++; $display("FAIL zero_jk got=%h want=00", {j, k}); end
    tick();
    total++; if ({done, cmd_ready} !== 2'b01) begin bad++; $display("FAIL zero_idle got=%b want=01", {done, cmd_ready}); end
  endtask

  task automatic test_back_to_back();
    load_val(4'h0);
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_steps = 4'h2;
    din       = 4'h0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy0 got=%b want=1", busy); end
    tick();
    total++; if ({q, cmd_ready} !== {4'h1, 1'b0}) begin bad++; $display("FAIL b2b_e1 got=%h/%b want=1/0", q, cmd_ready); end
    tick();
    total++; if ({q, done} !== {4'h2, 1'b1}) begin bad++; $display("FAIL b2b_e2 got=%h/%b want=2/1", q, done); end
    tick();
    total++; if ({q, busy, cmd_ready} !== {4'h2, 2'b01}) begin bad++; $display("FAIL b2b_idle got=%h/%b want=2/01", q, {busy, cmd_ready}); end
    tick();
    cmd_valid = 1'b0;
    total++; if ({q, busy, done} !== {4'h2, 2'b10}) begin bad++; $display("FAIL b2b_accept2 got=%h/%b want=2/10", q, {busy, done}); end
    tick();
    total++; if (q !== 4'h3) begin bad++; $display("FAIL b2b_q3 got=%h want=3", q); end
    tick();
    total++; if ({q, done} !== {4'h4, 1'b1}) begin bad++; $display("FAIL b2b_done2 got=%h/%b want=4/1", q, done); end
    tick();
  endtask

  task automatic test_reset_mid();
    load_val(4'h5);
    issue(OP_UP, 4'h4, 4'h0);
    tick();
    total++; if (q !== 4'h6) begin bad++; $display("FAIL mid_q6 got=%h want=6", q); end
    rst_n = 1'b0;
    #1;
    total++; if (q !== 4'h0) begin bad++; $display("FAIL mid_rst_q got=%h want=0", q); end
    total++; if ({busy, done, cmd_ready} !== 3'b001) begin bad++; $display("FAIL mid_rst_flags got=%b want=001", {busy, done, cmd_ready}); end
    total++; if ({j, k} !== 8'h00) begin bad++; $display("FAIL mid_rst_jk got=%h want=00", {j, k}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({done, q} !== 5'h00) begin bad++; $display("FAIL mid_rst_hold got=%h want=00", {done, q}); end
    end
    rst_n = 1'b1;
    issue(OP_LOAD, 4'h0, 4'h3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL post_rst_accept got=%b want=1", busy); end
    tick();
    total++; if ({q, done} !== {4'h3, 1'b1}) begin bad++; $display("FAIL post_rst_load got=%h/%b want=3/1", q, done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_up_wrap();
    test_down_wrap();
    test_hold();
    test_zero_steps();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
